// File: rtl/cv32e40p_id_ex_monitor_pkg.sv
// Shared types for the ID/EX protocol monitor: error indices, split FSM states, widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cv32e40p_id_ex_monitor_pkg;

    localparam int MON_ERR_W = 5;

    // Bit positions inside the sticky error vector
    typedef enum logic [2:0] {
        ERR_LSU_OVF = 3'd0,
        ERR_LSU_UNF = 3'd1,
        ERR_APU_CNT = 3'd2,
        ERR_SPLIT   = 3'd3,
        ERR_APU_DEP = 3'd4
    } mon_err_e;

    // Tracks whether the first half of a misaligned access has been granted
    typedef enum logic {
        MON_IDLE  = 1'b0,
        MON_SPLIT = 1'b1
    } mon_split_state_e;

endpackage

// File: rtl/cv32e40p_id_ex_monitor_if.sv
// Bundle of ID->EX issue, LSU and APU handshake signals observed by the monitor.
// Latency: n/a (wires only).
// Backpressure: none; the monitor modport is input-only and never drives the core.
interface cv32e40p_id_ex_monitor_if;

    logic id_valid;
    logic ex_ready;
    logic data_req;
    logic data_gnt;
    logic data_rvalid;
    logic data_misaligned;
    logic apu_req;
    logic apu_gnt;
    logic apu_rvalid;
    logic apu_read_dep;

    // Core side (or testbench) that produces the traffic
    modport master (
        output id_valid, ex_ready,
        output data_req, data_gnt, data_rvalid, data_misaligned,
        output apu_req, apu_gnt, apu_rvalid, apu_read_dep
    );

    // Monitor side, observe only
    modport slave (
        input id_valid, ex_ready,
        input data_req, data_gnt, data_rvalid, data_misaligned,
        input apu_req, apu_gnt, apu_rvalid, apu_read_dep
    );

endinterface

// File: rtl/cv32e40p_mon_outstd_cnt.sv
// Shadow up/down counter of outstanding transactions with overflow/underflow detection.
// Latency: count updates one cycle after inc/dec; ovf/unf flags are combinational from this cycle's inputs.
// Backpressure: none; saturates at MAX on overflow and holds on underflow.
module cv32e40p_mon_outstd_cnt #(
    parameter int unsigned MAX = 2,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         ovf_o,
    output logic         unf_o
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count and violation flags; a response with nothing outstanding wins over a
    // simultaneous grant, and the count is left untouched in that case
    always_comb begin
        count_d = count_q;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        if (dec_i && (count_q == '0)) begin
            unf_o = 1'b1;
        end else if (inc_i && !dec_i) begin
            if (count_q == MAX_C) begin
                ovf_o = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end else if (dec_i && !inc_i) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_id_ex_monitor.sv
// Non-intrusive ID/EX checker: shadow LSU/APU outstanding counts, misaligned split tracking,
// sticky error flags and saturating issue/stall statistics. SVA under CV32E40P_ID_EX_MON_ASSERT_EN.
// Latency: errors detected from cycle N inputs appear on err_o/err_new_o in cycle N+1.
// Backpressure: none; observe-only, never drives the core.
module cv32e40p_id_ex_monitor
    import cv32e40p_id_ex_monitor_pkg::*;
#(
    parameter int unsigned LSU_MAX_OUTSTD = 2,
    parameter int unsigned APU_MAX_OUTSTD = 2,
    parameter int unsigned CNT_W          = 16,
    localparam int unsigned LSU_W         = $clog2(LSU_MAX_OUTSTD + 1),
    localparam int unsigned APU_W         = $clog2(APU_MAX_OUTSTD + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    cv32e40p_id_ex_monitor_if.slave      mon_if,
    output logic [MON_ERR_W-1:0]         err_o,
    output logic                         err_new_o,
    output logic [LSU_W-1:0]             lsu_outstd_o,
    output logic [APU_W-1:0]             apu_outstd_o,
    output logic [CNT_W-1:0]             issue_cnt_o,
    output logic [CNT_W-1:0]             stall_cnt_o
);

    logic issue;
    logic stall;
    logic lsu_gnt;
    logic apu_gnt;

    logic lsu_ovf;
    logic lsu_unf;
    logic apu_ovf;
    logic apu_unf;

    logic [LSU_W-1:0] lsu_outstd;
    logic [APU_W-1:0] apu_outstd;

    mon_split_state_e split_q;

    logic [MON_ERR_W-1:0] err_det;
    logic [MON_ERR_W-1:0] err_d;
    logic [MON_ERR_W-1:0] err_q;
    logic                 err_new_d;
    logic                 err_new_q;
    logic [CNT_W-1:0]     issue_cnt_d;
    logic [CNT_W-1:0]     issue_cnt_q;
    logic [CNT_W-1:0]     stall_cnt_d;
    logic [CNT_W-1:0]     stall_cnt_q;

    assign issue   = mon_if.id_valid & mon_if.ex_ready;
    assign stall   = mon_if.id_valid & ~mon_if.ex_ready;
    assign lsu_gnt = mon_if.data_req & mon_if.data_gnt;
    assign apu_gnt = mon_if.apu_req & mon_if.apu_gnt;

    cv32e40p_mon_outstd_cnt #(
        .MAX (LSU_MAX_OUTSTD),
        .W   (LSU_W)
    ) u_lsu_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (lsu_gnt),
        .dec_i   (mon_if.data_rvalid),
        .count_o (lsu_outstd),
        .ovf_o   (lsu_ovf),
        .unf_o   (lsu_unf)
    );

    cv32e40p_mon_outstd_cnt #(
        .MAX (APU_MAX_OUTSTD),
        .W   (APU_W)
    ) u_apu_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (apu_gnt),
        .dec_i   (mon_if.apu_rvalid),
        .count_o (apu_outstd),
        .ovf_o   (apu_ovf),
        .unf_o   (apu_unf)
    );

    // Split FSM: a misaligned first half must be followed by a non-misaligned second half
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            split_q <= MON_IDLE;
        end else begin
            case (split_q)
                MON_IDLE: begin
                    if (lsu_gnt && mon_if.data_misaligned) begin
                        split_q <= MON_SPLIT;
                    end
                end
                MON_SPLIT: begin
                    if (lsu_gnt && !mon_if.data_misaligned) begin
                        split_q <= MON_IDLE;
                    end
                end
                default: split_q <= MON_IDLE;
            endcase
        end
    end

    // Per-cycle violation detection from the current inputs and registered state
    always_comb begin
        err_det              = '0;
        err_det[ERR_LSU_OVF] = lsu_ovf;
        err_det[ERR_LSU_UNF] = lsu_unf;
        err_det[ERR_APU_CNT] = apu_ovf | apu_unf;
        err_det[ERR_SPLIT]   = (split_q == MON_SPLIT) &&
                               (issue || (lsu_gnt && mon_if.data_misaligned));
        err_det[ERR_APU_DEP] = issue && mon_if.apu_read_dep && (apu_outstd != '0);
    end

    // Sticky accumulation; the pulse marks only bits that were not already set
    always_comb begin
        err_d     = err_q | err_det;
        err_new_d = |(err_det & ~err_q);
    end

    // Saturating statistics; issue and stall cannot both be true in one cycle
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (issue && (issue_cnt_q != '1)) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Error and statistic registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q       <= '0;
            err_new_q   <= 1'b0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            err_q       <= err_d;
            err_new_q   <= err_new_d;
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign err_o        = err_q;
    assign err_new_o    = err_new_q;
    assign lsu_outstd_o = lsu_outstd;
    assign apu_outstd_o = apu_outstd;
    assign issue_cnt_o  = issue_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;

`ifdef CV32E40P_ID_EX_MON_ASSERT_EN
    assert_id_ex_lsu_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !err_det[ERR_LSU_OVF]);
    assert_id_ex_lsu_unf: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !err_det[ERR_LSU_UNF]);
    assert_id_ex_apu_cnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !err_det[ERR_APU_CNT]);
    assert_id_ex_split: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !err_det[ERR_SPLIT]);
    assert_id_ex_apu_dep: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !err_det[ERR_APU_DEP]);

    cover_id_ex_split_done: cover property (@(posedge clk_i) disable iff (!rst_ni)
        (split_q == MON_SPLIT) ##1 (split_q == MON_IDLE));
    cover_id_ex_lsu_full: cover property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_outstd == LSU_W'(LSU_MAX_OUTSTD));
`else
`endif

endmodule

// File: tb/tb_cv32e40p_id_ex_monitor.sv
// Scoreboard bench for the ID/EX monitor: a behavioural model queues expected outputs per
// driven cycle; they are popped and compared #1 after the following rising edge.
// Directed constant checks cover the listed scenarios on top of the model comparison.
module tb_cv32e40p_id_ex_monitor;
    import cv32e40p_id_ex_monitor_pkg::*;

    localparam int LSU_MAX = 2;
    localparam int APU_MAX = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cv32e40p_id_ex_monitor_if mon_if ();

    logic [4:0]       err_o;
    logic             err_new_o;
    logic [1:0]       lsu_outstd_o;
    logic [1:0]       apu_outstd_o;
    logic [CNT_W-1:0] issue_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;

    cv32e40p_id_ex_monitor #(
        .LSU_MAX_OUTSTD (LSU_MAX),
        .APU_MAX_OUTSTD (APU_MAX),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mon_if       (mon_if),
        .err_o        (err_o),
        .err_new_o    (err_new_o),
        .lsu_outstd_o (lsu_outstd_o),
        .apu_outstd_o (apu_outstd_o),
        .issue_cnt_o  (issue_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    typedef struct {
        logic [4:0] err;
        logic       err_new;
        int         lsu;
        int         apu;
        int         issue;
        int         stall;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int         m_lsu = 0;
    int         m_apu = 0;
    int         m_issue = 0;
    int         m_stall = 0;
    logic [4:0] m_err = '0;
    bit         m_split = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge
    task automatic cyc(input logic rst, input logic v, input logic r,
                       input logic dreq, input logic dgnt, input logic drv, input logic mis,
                       input logic areq, input logic agnt, input logic arv, input logic dep);
        exp_t       e;
        exp_t       got;
        logic [4:0] nw;
        bit         g, ag, iss;
        rst_n                  = rst;
        mon_if.id_valid        = v;
        mon_if.ex_ready        = r;
        mon_if.data_req        = dreq;
        mon_if.data_gnt        = dgnt;
        mon_if.data_rvalid     = drv;
        mon_if.data_misaligned = mis;
        mon_if.apu_req         = areq;
        mon_if.apu_gnt         = agnt;
        mon_if.apu_rvalid      = arv;
        mon_if.apu_read_dep    = dep;
        e.err_new = 1'b0;
        if (!rst) begin
            m_lsu = 0; m_apu = 0; m_issue = 0; m_stall = 0; m_err = '0; m_split = 1'b0;
        end else begin
            nw  = '0;
            g   = dreq && dgnt;
            ag  = areq && agnt;
            iss = v && r;
            if (iss && dep && m_apu != 0) nw[4] = 1'b1;
            if (m_split) begin
                if (iss || (g && mis)) nw[3] = 1'b1;
                if (g && !mis) m_split = 1'b0;
            end else if (g && mis) begin
                m_split = 1'b1;
            end
            if (drv && m_lsu == 0) nw[1] = 1'b1;
            else if (g && !drv) begin
                if (m_lsu == LSU_MAX) nw[0] = 1'b1; else m_lsu++;
            end else if (drv && !g) m_lsu--;
            if (arv && m_apu == 0) nw[2] = 1'b1;
            else if (ag && !arv) begin
                if (m_apu == APU_MAX) nw[2] = 1'b1; else m_apu++;
            end else if (arv && !ag) m_apu--;
            if (iss && m_issue < CNT_SAT) m_issue++;
            if (v && !r && m_stall < CNT_SAT) m_stall++;
            e.err_new = |(nw & ~m_err);
            m_err     = m_err | nw;
        end
        e.err = m_err; e.lsu = m_lsu; e.apu = m_apu; e.issue = m_issue; e.stall = m_stall;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_eq("err_o",     32'(err_o),        32'(got.err));
        check_eq("err_new_o", 32'(err_new_o),    32'(got.err_new));
        check_eq("lsu_outstd",32'(lsu_outstd_o), 32'(got.lsu));
        check_eq("apu_outstd",32'(apu_outstd_o), 32'(got.apu));
        check_eq("issue_cnt", 32'(issue_cnt_o),  32'(got.issue));
        check_eq("stall_cnt", 32'(stall_cnt_o),  32'(got.stall));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0,0, 0,0,0,0, 0,0,0, 0);
    endtask

    initial begin
        // Reset state
        cyc(0, 0,0, 0,0,0,0, 0,0,0, 0);
        cyc(0, 1,1, 1,1,0,1, 1,1,0, 1);
        check_eq("rst_err",   32'(err_o), 32'd0);
        check_eq("rst_split", 32'(dut.split_q), 32'(MON_IDLE));
        idle(1);

        // Two grants then two responses: 1,2,1,0
        cyc(1, 0,0, 1,1,0,0, 0,0,0, 0); check_eq("t1_lsu_a", 32'(lsu_outstd_o), 32'd1);
        cyc(1, 0,0, 1,1,0,0, 0,0,0, 0); check_eq("t1_lsu_b", 32'(lsu_outstd_o), 32'd2);
        cyc(1, 0,0, 0,0,1,0, 0,0,0, 0); check_eq("t1_lsu_c", 32'(lsu_outstd_o), 32'd1);
        cyc(1, 0,0, 0,0,1,0, 0,0,0, 0); check_eq("t1_lsu_d", 32'(lsu_outstd_o), 32'd0);
        check_eq("t1_err", 32'(err_o), 32'd0);

        // Third grant at full occupancy
        cyc(1, 0,0, 1,1,0,0, 0,0,0, 0);
        cyc(1, 0,0, 1,1,0,0, 0,0,0, 0);
        cyc(1, 0,0, 1,1,0,0, 0,0,0, 0);
        check_eq("t2_err0", 32'(err_o), 32'd1);
        check_eq("t2_new",  32'(err_new_o), 32'd1);
        check_eq("t2_hold", 32'(lsu_outstd_o), 32'd2);
        idle(1);
        check_eq("t2_new_off", 32'(err_new_o), 32'd0);
        cyc(1, 0,0, 0,0,1,0, 0,0,0, 0);
        cyc(1, 0,0, 0,0,1,0, 0,0,0, 0);

        // Grant+response with count 0 underflows; with count 1 it is neutral
        cyc(1, 0,0, 1,1,1,0, 0,0,0, 0);
        check_eq("t5_unf",  32'(err_o[1]), 32'd1);
        check_eq("t5_cnt0", 32'(lsu_outstd_o), 32'd0);
        cyc(1, 0,0, 1,1,0,0, 0,0,0, 0);
        cyc(1, 0,0, 1,1,1,0, 0,0,0, 0);
        check_eq("t5_cnt1", 32'(lsu_outstd_o), 32'd1);
        check_eq("t5_nonew", 32'(err_new_o), 32'd0);
        cyc(1, 0,0, 0,0,1,0, 0,0,0, 0);

        // APU dependency: harmless with nothing outstanding, error with one outstanding
        cyc(1, 1,1, 0,0,0,0, 0,0,0, 1);
        check_eq("t4_nodep", 32'(err_o[4]), 32'd0);
        cyc(1, 0,0, 0,0,0,0, 1,1,0, 0);
        cyc(1, 1,1, 0,0,0,0, 0,0,0, 1);
        check_eq("t4_dep", 32'(err_o[4]), 32'd1);
        cyc(1, 1,0, 0,0,0,0, 0,0,1, 1);
        cyc(1, 0,0, 0,0,0,0, 0,0,1, 0);
        check_eq("t4_apu_unf", 32'(err_o[2]), 32'd1);

        // Issue while a misaligned split is pending
        cyc(1, 0,0, 1,1,0,1, 0,0,0, 0);
        check_eq("t3_split", 32'(dut.split_q), 32'(MON_SPLIT));
        cyc(1, 1,1, 0,0,0,0, 0,0,0, 0);
        check_eq("t3_err3", 32'(err_o[3]), 32'd1);
        check_eq("t3_stay", 32'(dut.split_q), 32'(MON_SPLIT));
        idle(2);
        check_eq("t3_stay2", 32'(dut.split_q), 32'(MON_SPLIT));
        cyc(1, 0,0, 1,1,0,0, 0,0,0, 0);
        check_eq("t3_done", 32'(dut.split_q), 32'(MON_IDLE));
        cyc(1, 0,0, 0,0,1,0, 0,0,0, 0);
        cyc(1, 0,0, 0,0,1,0, 0,0,0, 0);

        // Reset in the middle of a split discards everything
        cyc(1, 0,0, 1,1,0,1, 1,1,0, 0);
        cyc(0, 0,0, 0,0,0,0, 0,0,0, 0);
        check_eq("t6_rst_split", 32'(dut.split_q), 32'(MON_IDLE));
        check_eq("t6_rst_err",   32'(err_o), 32'd0);
        check_eq("t6_rst_lsu",   32'(lsu_outstd_o), 32'd0);

        // Issue counter saturation, then stall cycles
        for (int i = 0; i < 20; i++) cyc(1, 1,1, 0,0,0,0, 0,0,0, 0);
        check_eq("t6_sat", 32'(issue_cnt_o), 32'd15);
        for (int i = 0; i < 3; i++) cyc(1, 1,0, 0,0,0,0, 0,0,0, 0);
        check_eq("t6_stall", 32'(stall_cnt_o), 32'd3);
        check_eq("t6_err_clean", 32'(err_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
